atm_channel_sequencer: RTL and testbench

//  Upstream controller for the analog channel mux. Walks the enabled channels in

---
 rtl/atm_channel_sequencer.sv | 167 ++++++++++++++++
 tb/tb_atm_channel_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_channel_sequencer.sv
// Analog channel mux sequencer: walks the enabled channels (and an optional
// temperature slot), settles each one, then hands the captured sample downstream.
module atm_channel_sequencer #(
  parameter int DATA_W   = 16,
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [7:0]          chen,
  input  logic                tempen,
  input  logic [SETTLE_W-1:0] settle,
  output logic [7:0]          atmchsel,
  output logic                tempsel,
  input  logic [DATA_W-1:0]   mux_in,
  output logic [DATA_W-1:0]   sample_data,
  output logic [3:0]          sample_tag,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                round_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_OUT} state_t;

  // Slot 0..7 is a channel, slot 8 is the temperature sensor.
  typedef struct packed {
    logic       found;
    logic [3:0] slot;
  } pick_t;

  localparam logic [3:0] TEMP_SLOT = 4'd8;

  function automatic pick_t lowest_slot(input logic [7:0] mask, input logic temp);
    pick_t p;
    p.found = temp;
    p.slot  = TEMP_SLOT;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        p.found = 1'b1;
        p.slot  = 4'(i);
      end
    end
    return p;
  endfunction

  // Next slot later in the same round; found=0 means the current slot ends the round.
  function automatic pick_t higher_slot(input logic [3:0] cur, input logic [7:0] mask,
                                        input logic temp);
    pick_t p;
    p.found = temp && (cur != TEMP_SLOT);
    p.slot  = TEMP_SLOT;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) > cur)) begin
        p.found = 1'b1;
        p.slot  = 4'(i);
      end
    end
    return p;
  endfunction

  function automatic logic [8:0] sel_of(input logic [3:0] slot);
    if (slot[3]) return 9'h100;
    return {1'b0, 8'b1 << slot[2:0]};
  endfunction

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [3:0]          slot_q, slot_d;
  logic [8:0]          sel_d;
  logic [DATA_W-1:0]   data_d;
  logic [3:0]          tag_d;
  logic                valid_d, round_done_d;
  logic                load;
  logic [3:0]          load_slot;
  pick_t               first_p, next_p;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    first_p      = lowest_slot(chen, tempen);
    next_p       = higher_slot(slot_q, chen, tempen);
    state_d      = state_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    sel_d        = {tempsel, atmchsel};
    data_d       = sample_data;
    tag_d        = sample_tag;
    valid_d      = sample_valid;
    round_done_d = 1'b0;
    load         = 1'b0;
    load_slot    = slot_q;

    case (state_q)
      ST_IDLE: begin
        if (enable && first_p.found) begin
          load      = 1'b1;
          load_slot = first_p.slot;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end else begin
          data_d  = mux_in;
          tag_d   = slot_q;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (sample_ready) begin
          valid_d      = 1'b0;
          round_done_d = !next_p.found;
          // next_p.found implies first_p.found, so one test covers both.
          if (enable && first_p.found) begin
            load      = 1'b1;
            load_slot = next_p.found ? next_p.slot : first_p.slot;
          end else begin
            state_d = ST_IDLE;
            sel_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase

    // Config is only sampled here, so mid-slot changes land on the next slot.
    if (load) begin
      state_d = ST_SETTLE;
      slot_d  = load_slot;
      cnt_d   = settle;
      sel_d   = sel_of(load_slot);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      slot_q       <= '0;
      atmchsel     <= '0;
      tempsel      <= 1'b0;
      sample_data  <= '0;
      sample_tag   <= '0;
      sample_valid <= 1'b0;
      round_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      {tempsel, atmchsel} <= sel_d;
      sample_data  <= data_d;
      sample_tag   <= tag_d;
      sample_valid <= valid_d;
      round_done   <= round_done_d;
    end
  end

endmodule

// File: tb/tb_atm_channel_sequencer.sv
// Directed bench for atm_channel_sequencer: a behavioural mux returns 16'h1000+ch
// for channels and temp_val for the temperature slot.
module tb_atm_channel_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [7:0]  chen;
  logic        tempen;
  logic [3:0]  settle;
  logic [7:0]  atmchsel;
  logic        tempsel;
  logic [15:0] mux_in;
  logic [15:0] sample_data;
  logic [3:0]  sample_tag;
  logic        sample_valid;
  logic        sample_ready;
  logic        round_done;
  logic [15:0] temp_val;

  int checks = 0;
  int errors = 0;

  atm_channel_sequencer #(.DATA_W(16), .SETTLE_W(4)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .chen(chen), .tempen(tempen),
    .settle(settle), .atmchsel(atmchsel), .tempsel(tempsel), .mux_in(mux_in),
    .sample_data(sample_data), .sample_tag(sample_tag), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .round_done(round_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    mux_in = 16'h0000;
    if (tempsel) mux_in = temp_val;
    else
      for (int i = 0; i < 8; i++)
        if (atmchsel[i]) mux_in = 16'h1000 + 16'(i);
  end

  // Select invariant checked every cycle while out of reset.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      checks++;
      if ((tempsel && atmchsel != 8'h00) || $countones(atmchsel) > 1) begin
        errors++;
        $display("FAIL sel_invariant: atmchsel=%h tempsel=%b", atmchsel, tempsel);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic go_idle();
    sample_ready = 1'b1;
    enable = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; chen = 8'h00; tempen = 1'b0; settle = 4'd0;
    sample_ready = 1'b0; temp_val = 16'hBEEF;
    #12;
    checks++;
    if ({atmchsel, tempsel, sample_data, sample_tag, sample_valid, round_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: sel=%h temp=%b data=%h tag=%h valid=%b rd=%b expected all 0",
               atmchsel, tempsel, sample_data, sample_tag, sample_valid, round_done);
    end
    #1 resetn = 1'b1;
    step();
    checks++;
    if (atmchsel !== 8'h00 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: sel=%h valid=%b expected 00/0", atmchsel, sample_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_tag [4];
    int n = 0, last = 0;
    logic prev_v = 1'b0;
    logic [3:0] prev_tag = 4'd0;
    exp_tag = '{4'd0, 4'd2, 4'd0, 4'd2};
    chen = 8'h05; tempen = 1'b0; settle = 4'd2; sample_ready = 1'b1; enable = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      step();
      checks++;
      if (round_done !== (prev_v && prev_tag == 4'd2)) begin
        errors++;
        $display("FAIL rr_round_done cyc %0d: got %b expected %b", cyc, round_done,
                 prev_v && prev_tag == 4'd2);
      end
      prev_v = sample_valid; prev_tag = sample_tag;
      if (sample_valid) begin
        if (n < 4) begin
          checks++;
          if (sample_tag !== exp_tag[n] || sample_data !== 16'h1000 + 16'(exp_tag[n]) ||
              atmchsel !== 8'h01 << exp_tag[n] || cyc - last != 4) begin
            errors++;
            $display("FAIL rr_sample %0d: tag=%h data=%h sel=%h gap=%0d expected tag=%h data=%h sel=%h gap=4",
                     n, sample_tag, sample_data, atmchsel, cyc - last, exp_tag[n],
                     16'h1000 + 16'(exp_tag[n]), 8'h01 << exp_tag[n]);
          end
        end
        n++;
        last = cyc;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_count: got %0d samples expected 4", n);
    end
    go_idle();
  endtask

  task automatic test_temp_slot();
    logic [3:0] exp_tag [4];
    int n = 0, last = 0;
    logic prev_v = 1'b0;
    logic [3:0] prev_tag = 4'd0;
    logic [15:0] exp_data;
    exp_tag = '{4'd7, 4'd8, 4'd7, 4'd8};
    chen = 8'h80; tempen = 1'b1; settle = 4'd1; sample_ready = 1'b1; enable = 1'b1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      step();
      checks++;
      if (round_done !== (prev_v && prev_tag == 4'd8)) begin
        errors++;
        $display("FAIL temp_round_done cyc %0d: got %b expected %b", cyc, round_done,
                 prev_v && prev_tag == 4'd8);
      end
      prev_v = sample_valid; prev_tag = sample_tag;
      if (sample_valid) begin
        if (n < 4) begin
          exp_data = (exp_tag[n] == 4'd8) ? 16'hBEEF : 16'h1007;
          checks++;
          if (sample_tag !== exp_tag[n] || sample_data !== exp_data || cyc - last != 3 ||
              tempsel !== (exp_tag[n] == 4'd8) ||
              atmchsel !== ((exp_tag[n] == 4'd8) ? 8'h00 : 8'h80)) begin
            errors++;
            $display("FAIL temp_sample %0d: tag=%h data=%h sel=%h temp=%b gap=%0d expected tag=%h data=%h gap=3",
                     n, sample_tag, sample_data, atmchsel, tempsel, cyc - last, exp_tag[n], exp_data);
          end
        end
        n++;
        last = cyc;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL temp_count: got %0d samples expected 4", n);
    end
    tempen = 1'b0;
    go_idle();
  endtask

  task automatic test_backpressure();
    bit ok;
    chen = 8'h05; settle = 4'd0; sample_ready = 1'b0; enable = 1'b1;
    wait_valid(10, ok);
    checks++;
    if (!ok || sample_tag !== 4'd0 || sample_data !== 16'h1000 || atmchsel !== 8'h01) begin
      errors++;
      $display("FAIL bp_first: ok=%b tag=%h data=%h sel=%h expected 1/0/1000/01",
               ok, sample_tag, sample_data, atmchsel);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (sample_valid !== 1'b1 || sample_tag !== 4'd0 || sample_data !== 16'h1000 ||
          atmchsel !== 8'h01) begin
        errors++;
        $display("FAIL bp_hold %0d: valid=%b tag=%h data=%h sel=%h expected 1/0/1000/01",
                 i, sample_valid, sample_tag, sample_data, atmchsel);
      end
    end
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    checks++;
    if (sample_valid !== 1'b0 || atmchsel !== 8'h04 || tempsel !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: valid=%b sel=%h expected 0/04", sample_valid, atmchsel);
    end
    step();
    checks++;
    if (sample_valid !== 1'b1 || sample_tag !== 4'd2 || sample_data !== 16'h1002) begin
      errors++;
      $display("FAIL bp_next: valid=%b tag=%h data=%h expected 1/2/1002",
               sample_valid, sample_tag, sample_data);
    end
    go_idle();
  endtask

  task automatic test_enable_drop();
    bit ok;
    chen = 8'h01; settle = 4'd5; sample_ready = 1'b1; enable = 1'b1;
    repeat (3) step();
    enable = 1'b0;
    step();
    checks++;
    if (atmchsel !== 8'h00 || tempsel !== 1'b0 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_settle: sel=%h temp=%b valid=%b expected 00/0/0",
               atmchsel, tempsel, sample_valid);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (sample_valid !== 1'b0 || atmchsel !== 8'h00) begin
        errors++;
        $display("FAIL drop_idle %0d: valid=%b sel=%h expected 0/00", i, sample_valid, atmchsel);
      end
    end
    sample_ready = 1'b0; settle = 4'd0; enable = 1'b1;
    wait_valid(10, ok);
    enable = 1'b0;
    repeat (3) step();
    checks++;
    if (!ok || sample_valid !== 1'b1 || sample_tag !== 4'd0 || sample_data !== 16'h1000) begin
      errors++;
      $display("FAIL drop_out_hold: ok=%b valid=%b tag=%h data=%h expected 1/1/0/1000",
               ok, sample_valid, sample_tag, sample_data);
    end
    sample_ready = 1'b1;
    step();
    step();
    checks++;
    if (sample_valid !== 1'b0 || atmchsel !== 8'h00) begin
      errors++;
      $display("FAIL drop_out_idle: valid=%b sel=%h expected 0/00", sample_valid, atmchsel);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    chen = 8'h03; settle = 4'd0; sample_ready = 1'b0; enable = 1'b1;
    wait_valid(10, ok);
    checks++;
    if (!ok || sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_setup: ok=%b valid=%b expected 1/1", ok, sample_valid);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({atmchsel, tempsel, sample_data, sample_tag, sample_valid, round_done} !== '0) begin
      errors++;
      $display("FAIL ar_clear: sel=%h data=%h tag=%h valid=%b expected all 0",
               atmchsel, sample_data, sample_tag, sample_valid);
    end
    chen = 8'h0C; sample_ready = 1'b1;
    #2 resetn = 1'b1;
    wait_valid(10, ok);
    checks++;
    if (!ok || sample_tag !== 4'd2 || sample_data !== 16'h1002 || atmchsel !== 8'h04) begin
      errors++;
      $display("FAIL ar_restart: ok=%b tag=%h data=%h sel=%h expected 1/2/1002/04",
               ok, sample_tag, sample_data, atmchsel);
    end
    go_idle();
  endtask

  task automatic test_no_slots_and_midchange();
    bit ok;
    chen = 8'h00; tempen = 1'b0; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (atmchsel !== 8'h00 || tempsel !== 1'b0 || sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL noslot %0d: sel=%h temp=%b valid=%b expected 00/0/0",
                 i, atmchsel, tempsel, sample_valid);
      end
    end
    chen = 8'h05; settle = 4'd3; sample_ready = 1'b1;
    step();
    step();
    chen = 8'h02;
    wait_valid(10, ok);
    checks++;
    if (!ok || sample_tag !== 4'd0 || sample_data !== 16'h1000) begin
      errors++;
      $display("FAIL mid_first: ok=%b tag=%h data=%h expected 1/0/1000", ok, sample_tag, sample_data);
    end
    wait_valid(10, ok);
    checks++;
    if (!ok || sample_tag !== 4'd1 || sample_data !== 16'h1001 || atmchsel !== 8'h02) begin
      errors++;
      $display("FAIL mid_second: ok=%b tag=%h data=%h sel=%h expected 1/1/1001/02",
               ok, sample_tag, sample_data, atmchsel);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_temp_slot();
    test_backpressure();
    test_enable_drop();
    test_async_reset();
    test_no_slots_and_midchange();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
